// File: rtl/serial_mac_engine.sv
// Multi-channel serial multiply-accumulate engine.
// Streams feature/weight pairs from sync-read memories, emits saturated results.
module serial_mac_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int VEC_LEN   = 9,
    parameter int NUM_CH    = 2,
    parameter int OUT_SHIFT = 0,
    localparam int ACC_W    = 2 * DATA_W + $clog2(VEC_LEN),
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] feature_baseaddr,
    input  logic [ADDR_W-1:0] weight_baseaddr,
    input  logic              relu_en,
    output logic [ADDR_W-1:0] f_addr_o,
    input  logic [DATA_W-1:0] f_data_i,
    output logic [ADDR_W-1:0] w_addr_o,
    input  logic [DATA_W-1:0] w_data_i,
    output logic [DATA_W-1:0] out,
    output logic [CH_W-1:0]   out_ch_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              is_done_o
);

    localparam int K_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;

    state_t state, state_nx;

    logic [K_W-1:0]    k;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] fbase;
    logic              relu_q;
    logic              k_last;
    logic              ch_last;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shf;
    logic signed [ACC_W-1:0]    clamp;
    logic signed [ACC_W-1:0]    sat;

    assign k_last  = (k == K_W'(VEC_LEN - 1));
    assign ch_last = (ch == CH_W'(NUM_CH - 1));
    assign busy_o  = (state != IDLE);

    // Full-width signed product; memory data arrives one cycle after its address.
    assign prod  = $signed({{DATA_W{f_data_i[DATA_W-1]}}, f_data_i})
                 * $signed({{DATA_W{w_data_i[DATA_W-1]}}, w_data_i});
    assign sum   = acc + ACC_W'(prod);
    assign shf   = sum >>> OUT_SHIFT;
    assign clamp = (relu_q && shf[ACC_W-1]) ? '0 : shf;
    assign sat   = (clamp > SMAX) ? SMAX :
                   (clamp < SMIN) ? SMIN : clamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (k_last) state_nx = DRAIN;
            DRAIN:   state_nx = EMIT;
            EMIT:    state_nx = ch_last ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The result is registered on the DRAIN edge so it is visible during EMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k           <= '0;
            ch          <= '0;
            acc         <= '0;
            fbase       <= '0;
            relu_q      <= 1'b0;
            f_addr_o    <= '0;
            w_addr_o    <= '0;
            out         <= '0;
            out_ch_o    <= '0;
            out_valid_o <= 1'b0;
            is_done_o   <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            is_done_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        fbase    <= feature_baseaddr;
                        relu_q   <= relu_en;
                        f_addr_o <= feature_baseaddr;
                        w_addr_o <= weight_baseaddr;
                        k        <= '0;
                        ch       <= '0;
                        acc      <= '0;
                    end
                end
                RUN: begin
                    if (k != '0) acc <= sum;
                    if (!k_last) begin
                        k        <= k + K_W'(1);
                        f_addr_o <= f_addr_o + ADDR_W'(1);
                        w_addr_o <= w_addr_o + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    acc         <= sum;
                    out         <= sat[DATA_W-1:0];
                    out_ch_o    <= ch;
                    out_valid_o <= 1'b1;
                end
                EMIT: begin
                    if (!ch_last) begin
                        ch       <= ch + CH_W'(1);
                        k        <= '0;
                        acc      <= '0;
                        f_addr_o <= fbase;
                        w_addr_o <= w_addr_o + ADDR_W'(1);
                    end else begin
                        is_done_o <= 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mac_engine.sv
// Bench for serial_mac_engine: scoreboarded results, timing, wrap and reset.
module tb_serial_mac_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] fbase_in;
    logic [7:0] wbase_in;
    logic       relu;
    logic [7:0] f_addr, w_addr, f_data, w_data;
    logic [7:0] f_addr_s, w_addr_s, f_data_s, w_data_s;
    logic [7:0] out, out_s;
    logic [0:0] out_ch, out_ch_s;
    logic       out_valid, out_valid_s;
    logic       busy, busy_s;
    logic       done, done_s;

    logic [7:0] fmem [256];
    logic [7:0] wmem [256];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] val;
        logic [0:0] ch;
        int         cyc;
    } exp_t;

    exp_t       sb   [$];
    logic [7:0] sb_s [$];
    int         dn_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        f_data   <= fmem[f_addr];
        w_data   <= wmem[w_addr];
        f_data_s <= fmem[f_addr_s];
        w_data_s <= wmem[w_addr_s];
    end

    serial_mac_engine u_dut (
        .clk(clk), .rst(rst), .en(en),
        .feature_baseaddr(fbase_in), .weight_baseaddr(wbase_in),
        .relu_en(relu),
        .f_addr_o(f_addr), .f_data_i(f_data),
        .w_addr_o(w_addr), .w_data_i(w_data),
        .out(out), .out_ch_o(out_ch), .out_valid_o(out_valid),
        .busy_o(busy), .is_done_o(done)
    );

    serial_mac_engine #(.OUT_SHIFT(4)) u_shf (
        .clk(clk), .rst(rst), .en(en),
        .feature_baseaddr(fbase_in), .weight_baseaddr(wbase_in),
        .relu_en(relu),
        .f_addr_o(f_addr_s), .f_data_i(f_data_s),
        .w_addr_o(w_addr_s), .w_data_i(w_data_s),
        .out(out_s), .out_ch_o(out_ch_s), .out_valid_o(out_valid_s),
        .busy_o(busy_s), .is_done_o(done_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] fb,
                                         input logic [7:0] wb,
                                         input int c, input bit rl,
                                         input int sh);
        longint acc = 0;
        for (int i = 0; i < 9; i++) begin
            acc += longint'($signed(fmem[8'(fb + i)]))
                 * longint'($signed(wmem[8'(wb + c * 9 + i)]));
        end
        acc = acc >>> sh;
        if (rl && acc < 0) acc = 0;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return 8'(acc);
    endfunction

    // Cycle S is the IDLE cycle in which en is sampled.
    task automatic push_job(input int s, input logic [7:0] fb,
                            input logic [7:0] wb, input bit rl);
        for (int c = 0; c < 2; c++) begin
            sb.push_back('{model(fb, wb, c, rl, 0), 1'(c), s + 11 + 11 * c});
            sb_s.push_back(model(fb, wb, c, rl, 4));
        end
        dn_q.push_back(s + 23);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(out), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", 32'(out), 32'(e.val));
                chk("out_ch", 32'(out_ch), 32'(e.ch));
                chk("valid_cycle", cyc, e.cyc);
            end
        end
        if (out_valid_s) begin
            if (sb_s.size() == 0) begin
                chk("unexpected_valid_shift", 32'(out_s), 32'hDEAD);
            end else begin
                chk("out_shift", 32'(out_s), 32'(sb_s.pop_front()));
            end
        end
        if (done) begin
            if (dn_q.size() == 0) chk("unexpected_done", cyc, 32'hDEAD);
            else chk("done_cycle", cyc, dn_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        int n = 0;
        while (cyc < c && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic start(input logic [7:0] fb, input logic [7:0] wb,
                         input bit rl, input bit hold, input bit track,
                         output int s);
        en       = 1'b1;
        fbase_in = fb;
        wbase_in = wb;
        relu     = rl;
        s        = cyc;
        if (track) push_job(s, fb, wb, rl);
        if (!hold) begin
            step();
            en = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || dn_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        step();
        chk("drain", 32'(sb.size() + sb_s.size() + dn_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int hits;
        rst      = 1'b0;
        en       = 1'b0;
        fbase_in = '0;
        wbase_in = '0;
        relu     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            fmem[i] = '0;
            wmem[i] = '0;
        end
        for (int i = 9; i < 18; i++) fmem[i] = 8'd1;
        fmem[18] = 8'd3;
        for (int i = 0; i < 9; i++) wmem[i] = 8'(i + 1);
        for (int i = 9; i < 18; i++) wmem[i] = 8'd2;
        for (int i = 8'h20; i < 8'h29; i++) fmem[i] = 8'd127;
        for (int i = 8'h40; i < 8'h52; i++) wmem[i] = 8'd127;
        for (int i = 8'h60; i < 8'h72; i++) wmem[i] = 8'h80;

        // Reset held with en toggling
        for (int i = 0; i < 4; i++) begin
            en = ~en;
            step();
        end
        chk("rst_out", 32'(out), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_f_addr", 32'(f_addr), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        en  = 1'b0;
        rst = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hits += int'(busy) + int'(out_valid) + int'(done);
        end
        chk("idle_after_reset", hits, 0);

        // Basic job
        start(8'd9, 8'd0, 1'b0, 1'b0, 1'b1, s);
        wait_to(s + 1);
        chk("basic_first_f_addr", 32'(f_addr), 9);
        chk("basic_first_w_addr", 32'(w_addr), 0);
        wait_to(s + 12);
        chk("basic_ch1_w_addr", 32'(w_addr), 9);
        drain();

        // Saturation high, low, and ReLU
        start(8'h20, 8'h40, 1'b0, 1'b0, 1'b1, s);
        drain();
        start(8'h20, 8'h60, 1'b0, 1'b0, 1'b1, s);
        drain();
        start(8'h20, 8'h60, 1'b1, 1'b0, 1'b1, s);
        drain();

        // Back-to-back with en held high
        start(8'd9, 8'd0, 1'b0, 1'b1, 1'b1, s);
        wait_to(s + 24);
        chk("b2b_idle_gap", 32'(busy), 0);
        fbase_in = 8'd10;
        push_job(s + 24, 8'd10, 8'd0, 1'b0);
        wait_to(s + 25);
        chk("b2b_first_f_addr", 32'(f_addr), 10);
        chk("b2b_busy", 32'(busy), 1);
        en = 1'b0;
        drain();

        // Address wrap, then reset mid-job
        start(8'hFC, 8'd0, 1'b0, 1'b0, 1'b0, s);
        for (int i = 1; i <= 5; i++) begin
            wait_to(s + i);
            chk("wrap_f_addr", 32'(f_addr), 32'(8'(8'hFC + i - 1)));
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_f_addr", 32'(f_addr), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out", 32'(out), 0);
        step();
        rst = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            hits += int'(out_valid) + int'(done) + int'(busy);
        end
        chk("no_output_after_midrst", hits, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
